mem_io_responder: RTL and testbench

- Responder end of the CPU's byte-wide memory bus (mem_a / mem_wr / mem_dout / mem_din).
- Serves 128KB of byte RAM plus the memory-mapped I/O window: UART byte in/out, cycle counter, program stop.
- Generates the ready/stall signal that freezes the CPU while an I/O access cannot complete.
- Sits between the CPU and the UART/host interface in the top-level SoC.

---
 rtl/mem_io_responder_if.sv | 12 +
 rtl/mem_io_responder.sv | 144 ++++++++++++++
 tb/tb_mem_io_responder.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_io_responder_if.sv
// Byte-wide CPU memory bus: the address, write strobe and write data come from the CPU.
// The read data and the ready/stall signal come back from the responder.
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        cpu_rdy;

    modport master (output mem_a, mem_wr, mem_dout, input mem_din, cpu_rdy);
    modport slave  (input mem_a, mem_wr, mem_dout, output mem_din, cpu_rdy);
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU bus responder for byte RAM plus the UART / cycle counter / program-stop I/O window.
// Build option MEM_IO_RX_NONBLOCK_EN: an I/O read of an empty RX returns 0x00 instead of stalling.
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_FIFO_DEPTH  = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    mem_io_responder_if.slave bus,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              prog_stop
);
    localparam int PTR_W = $clog2(TX_FIFO_DEPTH);

    logic [7:0] ram [0:(1 << RAM_ADDR_WIDTH) - 1];
    logic [7:0] fifo_mem [0:TX_FIFO_DEPTH - 1];

    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic [2:0]  io_off;
    logic        is_ram;
    logic        is_io;
    logic        rx_rd;
    logic        push_req;
    logic        rx_stall;
    logic        tx_stall;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic [7:0]  push_data;
    logic [7:0]  io_rdata;
    logic        unused_hi;

    logic [PTR_W:0] wr_ptr_p0;
    logic [PTR_W:0] rd_ptr_p0;
    logic        rd_ram_p0;
    logic [7:0]  ram_q_p0;
    logic [7:0]  io_q_p0;
    logic [31:0] cycle_cnt_p0;
    logic [31:0] snap_p0;

    assign unused_hi = ^bus.mem_a[31:18];

    assign ram_idx  = bus.mem_a[RAM_ADDR_WIDTH-1:0];
    assign io_off   = bus.mem_a[2:0];
    assign is_ram   = !bus.mem_a[17];
    assign is_io    = (bus.mem_a[17:16] == 2'b11);
    assign rx_rd    = is_io && !bus.mem_wr && (io_off == 3'd0);
    assign push_req = is_io && bus.mem_wr && !prog_stop &&
                      (((io_off == 3'd0) && (bus.mem_dout != 8'h00)) || (io_off == 3'd4));

    assign fifo_empty = (wr_ptr_p0 == rd_ptr_p0);
    assign fifo_full  = (wr_ptr_p0[PTR_W] != rd_ptr_p0[PTR_W]) &&
                        (wr_ptr_p0[PTR_W-1:0] == rd_ptr_p0[PTR_W-1:0]);

`ifdef MEM_IO_RX_NONBLOCK_EN
    assign rx_stall = 1'b0;
`else
    assign rx_stall = rx_rd && !rx_valid;
`endif
    // A full FIFO stalls even when a pop lands in the same cycle; this keeps cpu_rdy off tx_ready.
    assign tx_stall = push_req && fifo_full;

    assign bus.cpu_rdy = rst_in && !rx_stall && !tx_stall;
    assign accept      = rdy_in && bus.cpu_rdy;
    assign rx_ready    = accept && rx_rd && rx_valid;

    assign push      = accept && push_req;
    assign pop       = !fifo_empty && tx_ready;
    assign push_data = (io_off == 3'd4) ? 8'h00 : bus.mem_dout;
    assign tx_valid  = !fifo_empty;
    assign tx_data   = fifo_mem[rd_ptr_p0[PTR_W-1:0]];

    always_comb begin
        io_rdata = 8'h00;
        if (is_io) begin
            case (io_off)
                3'd0:    io_rdata = rx_valid ? rx_data : 8'h00;
                3'd4:    io_rdata = cycle_cnt_p0[7:0];
                3'd5:    io_rdata = snap_p0[15:8];
                3'd6:    io_rdata = snap_p0[23:16];
                3'd7:    io_rdata = snap_p0[31:24];
                default: io_rdata = 8'h00;
            endcase
        end
    end

    // Stage p0: RAM and FIFO storage, captured on the accepted edge (not reset)
    always_ff @(posedge clk_in) begin
        if (accept && is_ram) begin
            if (bus.mem_wr) begin
                ram[ram_idx] <= bus.mem_dout;
            end else begin
                ram_q_p0 <= ram[ram_idx];
            end
        end
        if (push) begin
            fifo_mem[wr_ptr_p0[PTR_W-1:0]] <= push_data;
        end
    end

    // Stage p0: read-data select, FIFO pointers, counter, snapshot, stop flag
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_ram_p0    <= 1'b0;
            io_q_p0      <= 8'h00;
            wr_ptr_p0    <= '0;
            rd_ptr_p0    <= '0;
            cycle_cnt_p0 <= 32'd0;
            snap_p0      <= 32'd0;
            prog_stop    <= 1'b0;
        end else begin
            if (accept && !bus.mem_wr) begin
                rd_ram_p0 <= is_ram;
                io_q_p0   <= io_rdata;
                if (is_io && (io_off == 3'd4)) begin
                    snap_p0 <= cycle_cnt_p0;
                end
            end
            if (push) begin
                wr_ptr_p0 <= wr_ptr_p0 + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr_p0 <= rd_ptr_p0 + (PTR_W+1)'(1);
            end
            if (push && (io_off == 3'd4)) begin
                prog_stop <= 1'b1;
            end
            if (rdy_in) begin
                cycle_cnt_p0 <= cycle_cnt_p0 + 32'd1;
            end
        end
    end

    assign bus.mem_din = rd_ram_p0 ? ram_q_p0 : io_q_p0;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed and randomized bench for mem_io_responder against a queue/array reference model.
// Honours MEM_IO_RX_NONBLOCK_EN for the empty-RX read expectations.
module tb_mem_io_responder;
    localparam int DEPTH = 8;

    logic       clk_in;
    logic       rst_in;
    logic       rdy_in;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       prog_stop;

    mem_io_responder_if bus_if ();

    mem_io_responder #(.RAM_ADDR_WIDTH(17), .TX_FIFO_DEPTH(DEPTH)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .bus      (bus_if),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .prog_stop(prog_stop)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0]  m_ram [int];
    logic [7:0]  m_txq [$];
    bit          m_stop;
    bit [31:0]   m_cnt;
    bit [31:0]   m_snap;
    logic [7:0]  m_din;
    bit          m_din_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
        bus_if.mem_a    = a;
        bus_if.mem_wr   = wr;
        bus_if.mem_dout = d;
    endtask

    task automatic model_reset();
        m_txq.delete();
        m_stop   = 1'b0;
        m_cnt    = 32'd0;
        m_snap   = 32'd0;
        m_din    = 8'h00;
        m_din_ok = 1'b1;
    endtask

    // One clock: check outputs at the falling edge, then apply the spec rules at the rising edge.
    task automatic cycle();
        logic [31:0] a;
        logic        wr;
        logic [7:0]  d;
        logic [2:0]  off;
        bit is_ram, is_io, rx_rd, push_q, exp_rdy, acc;
        a   = bus_if.mem_a;
        wr  = bus_if.mem_wr;
        d   = bus_if.mem_dout;
        off = a[2:0];
        is_ram = (a[17] == 1'b0);
        is_io  = (a[17:16] == 2'b11);
        rx_rd  = is_io && !wr && (off == 3'd0);
        push_q = is_io && wr && !m_stop && (((off == 3'd0) && (d != 8'h00)) || (off == 3'd4));
        exp_rdy = 1'b1;
`ifndef MEM_IO_RX_NONBLOCK_EN
        if (rx_rd && !rx_valid) exp_rdy = 1'b0;
`endif
        if (push_q && (m_txq.size() == DEPTH)) exp_rdy = 1'b0;
        if (!rst_in) exp_rdy = 1'b0;

        @(negedge clk_in);
        chk("cpu_rdy", bus_if.cpu_rdy, exp_rdy);
        chk("rx_ready", rx_ready, exp_rdy && rdy_in && rx_rd && rx_valid);
        chk("tx_valid", tx_valid, m_txq.size() != 0);
        if (m_txq.size() != 0) chk("tx_data", tx_data, m_txq[0]);
        chk("prog_stop", prog_stop, m_stop);
        if (m_din_ok) chk("mem_din", bus_if.mem_din, m_din);

        @(posedge clk_in);
        if (rst_in) begin
            acc = rdy_in && exp_rdy;
            if ((m_txq.size() != 0) && tx_ready) void'(m_txq.pop_front());
            if (acc && push_q) begin
                m_txq.push_back((off == 3'd4) ? 8'h00 : d);
                if (off == 3'd4) m_stop = 1'b1;
            end
            if (acc && wr && is_ram) m_ram[int'(a[16:0])] = d;
            if (acc && !wr) begin
                m_din_ok = 1'b1;
                if (is_ram) begin
                    if (m_ram.exists(int'(a[16:0]))) m_din = m_ram[int'(a[16:0])];
                    else m_din_ok = 1'b0;
                end else if (!is_io) begin
                    m_din = 8'h00;
                end else begin
                    case (off)
                        3'd0: m_din = rx_valid ? rx_data : 8'h00;
                        3'd4: begin m_din = m_cnt[7:0]; m_snap = m_cnt; end
                        3'd5: m_din = m_snap[15:8];
                        3'd6: m_din = m_snap[23:16];
                        3'd7: m_din = m_snap[31:24];
                        default: m_din = 8'h00;
                    endcase
                end
            end
            if (rdy_in) m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic op(input logic [31:0] a, input logic wr, input logic [7:0] d);
        drive(a, wr, d);
        cycle();
    endtask

    task automatic apply_reset();
        #2;
        rst_in = 1'b0;
        #1;
        chk("rst_cpu_rdy", bus_if.cpu_rdy, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_prog_stop", prog_stop, 1'b0);
        chk("rst_mem_din", bus_if.mem_din, 8'h00);
        chk("rst_rx_ready", rx_ready, 1'b0);
        model_reset();
        cycle();
        cycle();
        rst_in = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  off;
        logic        wr;
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        drive(32'h0002_0000, 1'b0, 8'h00);
        apply_reset();

        // RAM write then read, then unmapped read
        op(32'h0000_0010, 1'b1, 8'hA5);
        op(32'h0000_0010, 1'b0, 8'h00);
        chk("ram_rd_a5", bus_if.mem_din, 8'hA5);

        // RX read: stall while empty, pop once a byte arrives
        rx_valid = 1'b0;
        drive(32'h0003_0000, 1'b0, 8'h00);
        #1;
`ifdef MEM_IO_RX_NONBLOCK_EN
        chk("rx_nb_rdy", bus_if.cpu_rdy, 1'b1);
        chk("rx_nb_ready", rx_ready, 1'b0);
        cycle();
        chk("rx_nb_din", bus_if.mem_din, 8'h00);
`else
        chk("rx_stall", bus_if.cpu_rdy, 1'b0);
        cycle();
        cycle();
        chk("rx_stall_hold", bus_if.cpu_rdy, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        #1;
        chk("rx_arrive_rdy", bus_if.cpu_rdy, 1'b1);
        chk("rx_arrive_ready", rx_ready, 1'b1);
        cycle();
        chk("rx_din_41", bus_if.mem_din, 8'h41);
`endif
        rx_valid = 1'b0;
        op(32'h0002_0010, 1'b0, 8'h00);
        chk("unmapped_rd", bus_if.mem_din, 8'h00);

        // Randomized traffic over RAM, unmapped and I/O space
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            wr = 1'($urandom_range(0, 1));
            if (r < 40) begin
                a = ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) a = a | 32'h0001_FFF0;
            end else if (r < 50) begin
                a = ($urandom & 32'hFFFC_FFFF) | 32'h0002_0000;
            end else begin
                off = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 0) off = 3'd0;
                if ((off == 3'd4) && wr && ($urandom_range(0, 40) != 0)) wr = 1'b0;
                a = ($urandom & 32'hFFFC_FFF8) | 32'h0003_0000 | 32'(off);
            end
            rx_valid = ($urandom_range(0, 2) != 0);
            rx_data  = 8'($urandom);
            tx_ready = 1'($urandom_range(0, 1));
            rdy_in   = ($urandom_range(0, 7) != 0);
            op(a, wr, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
        end
        rdy_in   = 1'b1;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        drive(32'h0002_0000, 1'b0, 8'h00);
        apply_reset();

        // TX FIFO fill, full stall, release by one pop, zero-byte write ignored
        for (int i = 0; i < DEPTH; i++) op(32'h0003_0000, 1'b1, 8'(8'h30 + i));
        drive(32'h0003_0000, 1'b1, 8'h38);
        #1;
        chk("tx_full_stall", bus_if.cpu_rdy, 1'b0);
        cycle();
        cycle();
        tx_ready = 1'b1;
        #1;
        chk("tx_full_pop_stall", bus_if.cpu_rdy, 1'b0);
        cycle();
        tx_ready = 1'b0;
        #1;
        chk("tx_after_pop_rdy", bus_if.cpu_rdy, 1'b1);
        cycle();
        op(32'h0003_0000, 1'b1, 8'h00);
        drive(32'h0002_0000, 1'b0, 8'h00);
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("tx_drain_data", tx_data, 8'(8'h31 + i));
            cycle();
        end
        chk("tx_drained", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Program stop: emits 0x00, later writes ignored
        op(32'h0003_0004, 1'b1, 8'h99);
        chk("stop_set", prog_stop, 1'b1);
        chk("stop_tx_valid", tx_valid, 1'b1);
        chk("stop_tx_zero", tx_data, 8'h00);
        op(32'h0003_0000, 1'b1, 8'h55);
        tx_ready = 1'b1;
        op(32'h0002_0000, 1'b0, 8'h00);
        chk("stop_no_push", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // Cycle counter snapshot
        apply_reset();
        drive(32'h0002_0000, 1'b0, 8'h00);
        for (int i = 0; i < 100; i++) cycle();
        rdy_in = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        rdy_in = 1'b1;
        op(32'h0003_0004, 1'b0, 8'h00);
        chk("cnt_b0", bus_if.mem_din, 8'd100);
        op(32'h0003_0005, 1'b0, 8'h00);
        chk("cnt_b1", bus_if.mem_din, 8'h00);
        op(32'h0003_0006, 1'b0, 8'h00);
        op(32'h0003_0007, 1'b0, 8'h00);
        chk("cnt_b3", bus_if.mem_din, 8'h00);

        // Reset in the middle of a stall with the FIFO half full and stop set
        for (int i = 0; i < 3; i++) op(32'h0003_0000, 1'b1, 8'(8'h11 + i));
        op(32'h0003_0004, 1'b1, 8'h01);
        rx_valid = 1'b0;
        drive(32'h0003_0000, 1'b0, 8'h00);
        cycle();
        cycle();
        apply_reset();
        drive(32'h0002_0000, 1'b0, 8'h00);
        cycle();
        cycle();
        cycle();
        op(32'h0003_0004, 1'b0, 8'h00);
        chk("cnt_restart", bus_if.mem_din, 8'd3);
        op(32'h0000_0010, 1'b0, 8'h00);
        chk("ram_kept", bus_if.mem_din, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
